// File: rtl/ml_regressor_axil_regbank.sv
// AXI4-Lite slave register bank for ml_regressor: byte-strobed R/W registers,
// read-only status registers fed from reg_in, self-clearing pulse registers and SLVERR decode.
module ml_regressor_axil_regbank #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS           = 16,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
    parameter logic [NUM_REGS-1:0] PULSE_MASK = '0
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS-1:0]                    wr_strobe
);

    localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
    localparam int unsigned NB       = DW / 8;
    localparam int unsigned ADDR_LSB = $clog2(NB);
    localparam int unsigned AIW      = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
    localparam int unsigned IW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [DW-1:0] regs   [NUM_REGS];
    logic [DW-1:0] status [NUM_REGS];

    // ---------------- write path ----------------
    w_state_t                      w_state, w_state_nxt;
    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q;
    logic [DW-1:0]                 w_data_q;
    logic [NB-1:0]                 w_strb_q;
    logic [1:0]                    bresp_q;
    logic                          aw_hs, w_hs, commit;
    logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr;
    logic [DW-1:0]                 wr_data;
    logic [NB-1:0]                 wr_strb;
    logic [AIW-1:0]                wr_idx_full;
    logic [IW-1:0]                 wr_idx;
    logic                          wr_in_range, wr_ok;

    assign S_AXI_AWREADY = (w_state == W_IDLE) || (w_state == W_HAVE_W);
    assign S_AXI_WREADY  = (w_state == W_IDLE) || (w_state == W_HAVE_AW);
    assign S_AXI_BVALID  = (w_state == W_RESP);
    assign S_AXI_BRESP   = bresp_q;
    assign aw_hs         = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs          = S_AXI_WVALID && S_AXI_WREADY;

    // The completing handshake commits on its own edge, so the channel that
    // arrives last is taken straight from the bus rather than from its latch.
    assign wr_addr     = (w_state == W_HAVE_AW) ? aw_addr_q : S_AXI_AWADDR;
    assign wr_data     = (w_state == W_HAVE_W) ? w_data_q : S_AXI_WDATA;
    assign wr_strb     = (w_state == W_HAVE_W) ? w_strb_q : S_AXI_WSTRB;
    assign wr_idx_full = wr_addr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
    assign wr_idx      = wr_idx_full[IW-1:0];
    assign wr_in_range = 32'(wr_idx_full) < NUM_REGS;
    assign wr_ok       = wr_in_range && !RO_MASK[wr_idx];

    always_comb begin
        w_state_nxt = w_state;
        commit      = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (S_AXI_AWVALID && S_AXI_WVALID) begin
                    commit      = 1'b1;
                    w_state_nxt = W_RESP;
                end else if (S_AXI_AWVALID) begin
                    w_state_nxt = W_HAVE_AW;
                end else if (S_AXI_WVALID) begin
                    w_state_nxt = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                if (S_AXI_WVALID) begin
                    commit      = 1'b1;
                    w_state_nxt = W_RESP;
                end
            end
            W_HAVE_W: begin
                if (S_AXI_AWVALID) begin
                    commit      = 1'b1;
                    w_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            w_state   <= W_IDLE;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state <= w_state_nxt;
            if (aw_hs) aw_addr_q <= S_AXI_AWADDR;
            if (w_hs) begin
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
            if (commit) bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // ---------------- register storage ----------------
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            wr_strobe <= '0;
        end else begin
            wr_strobe <= '0;
            // wr_strobe marks the commit cycle, so a pulse register clears one cycle later.
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (PULSE_MASK[i] && wr_strobe[i]) regs[i] <= '0;
            end
            if (commit && wr_ok) begin
                wr_strobe[wr_idx] <= 1'b1;
                for (int unsigned k = 0; k < NB; k++) begin
                    if (wr_strb[k]) regs[wr_idx][k*8 +: 8] <= wr_data[k*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            reg_out[i*DW +: DW] = regs[i];
            status[i]           = reg_in[i*DW +: DW];
        end
    end

    // ---------------- read path ----------------
    r_state_t       r_state, r_state_nxt;
    logic [DW-1:0]  rdata_q, rd_value;
    logic [1:0]     rresp_q;
    logic           ar_hs, rd_in_range;
    logic [AIW-1:0] rd_idx_full;
    logic [IW-1:0]  rd_idx;

    assign S_AXI_ARREADY = (r_state == R_IDLE);
    assign S_AXI_RVALID  = (r_state == R_DATA);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;
    assign rd_idx_full   = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
    assign rd_idx        = rd_idx_full[IW-1:0];
    assign rd_in_range   = 32'(rd_idx_full) < NUM_REGS;

    always_comb begin
        rd_value = '0;
        if (rd_in_range) begin
            if (RO_MASK[rd_idx]) rd_value = status[rd_idx];
            else                 rd_value = regs[rd_idx];
        end
    end

    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (S_AXI_ARVALID) r_state_nxt = R_DATA;
            R_DATA:  if (S_AXI_RREADY) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_state <= R_IDLE;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            r_state <= r_state_nxt;
            if (ar_hs) begin
                rdata_q <= rd_value;
                rresp_q <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         wr_addr[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

endmodule
